// File: rtl/legv8_ctrl_pkg.sv
// Shared types and encodings for the LEGv8 multi-cycle control unit:
// FSM states, decoded instruction classes, opcode patterns and datapath codes.
package legv8_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_MEM   = 3'd2,
    ST_BRCH  = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    CL_ILL  = 4'd0,
    CL_ADD  = 4'd1,
    CL_SUB  = 4'd2,
    CL_AND  = 4'd3,
    CL_ORR  = 4'd4,
    CL_ADDI = 4'd5,
    CL_SUBI = 4'd6,
    CL_LDUR = 4'd7,
    CL_STUR = 4'd8,
    CL_B    = 4'd9,
    CL_CBZ  = 4'd10
  } op_class_e;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;

  localparam logic [4:0] FS_AND   = 5'b00000;
  localparam logic [4:0] FS_ORR   = 5'b00100;
  localparam logic [4:0] FS_ADD   = 5'b01000;
  localparam logic [4:0] FS_SUB   = 5'b01001;
  localparam logic [4:0] FS_PASSB = 5'b11100;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_LOAD = 2'b10;
  localparam logic [1:0] PS_OFS  = 2'b11;

endpackage

// File: rtl/legv8_inst_decode.sv
// Combinational instruction decoder: classifies the latched instruction word
// and extracts register fields and the extended immediates of each format.
module legv8_inst_decode
  import legv8_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output op_class_e   cls,
  output logic [4:0]  rd,
  output logic [4:0]  rn,
  output logic [4:0]  rm,
  output logic [63:0] k_alu,
  output logic [63:0] k_dt,
  output logic [63:0] k_br,
  output logic [63:0] k_cb
);

  assign rd    = ir[4:0];
  assign rn    = ir[9:5];
  assign rm    = ir[20:16];
  assign k_alu = {52'd0, ir[21:10]};
  assign k_dt  = {{55{ir[20]}}, ir[20:12]};
  assign k_br  = {{38{ir[25]}}, ir[25:0]};
  assign k_cb  = {{45{ir[23]}}, ir[23:5]};

  // Opcode classification; the short-opcode formats are matched first.
  always_comb begin
    cls = CL_ILL;
    if (ir[31:26] == OP_B) begin
      cls = CL_B;
    end else if (ir[31:24] == OP_CBZ) begin
      cls = CL_CBZ;
    end else if (ir[31:22] == OP_ADDI) begin
      cls = CL_ADDI;
    end else if (ir[31:22] == OP_SUBI) begin
      cls = CL_SUBI;
    end else begin
      case (ir[31:21])
        OP_ADD:  cls = CL_ADD;
        OP_SUB:  cls = CL_SUB;
        OP_AND:  cls = CL_AND;
        OP_ORR:  cls = CL_ORR;
        OP_LDUR: cls = CL_LDUR;
        OP_STUR: cls = CL_STUR;
        default: cls = CL_ILL;
      endcase
    end
  end

endmodule

// File: rtl/legv8_control_unit.sv
// Multi-cycle LEGv8 control FSM: latches the ROM word in FETCH and Moore-decodes
// all datapath control pins from state and IR; counts retired instructions.
module legv8_control_unit
  import legv8_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      inst,
  input  logic [3:0]       PRESTAT,
  output logic [4:0]       SA,
  output logic [4:0]       SB,
  output logic [4:0]       DA,
  output logic             WR,
  output logic [4:0]       FS,
  output logic             C0,
  output logic [63:0]      K,
  output logic             M,
  output logic             EN_ALU,
  output logic             EN_ADDR_ALU,
  output logic             EN_B,
  output logic             EN_PC,
  output logic             EN_ADDR_PC,
  output logic             PC_SEL,
  output logic [1:0]       PS,
  output logic             RCS,
  output logic             RWE,
  output logic             ROE,
  output logic             SFL,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_class_e        cls;
  logic [4:0]       rd, rn, rm;
  logic [63:0]      k_alu, k_dt, k_br, k_cb;
  logic             unused_flags;

  // Only the Z flag steers CBZ; V, C and N are not consulted here.
  assign unused_flags = ^PRESTAT[3:1];
  assign instr_count  = cnt_q;

  legv8_inst_decode u_dec (
    .ir    (ir_q),
    .cls   (cls),
    .rd    (rd),
    .rn    (rn),
    .rm    (rm),
    .k_alu (k_alu),
    .k_dt  (k_dt),
    .k_br  (k_br),
    .k_cb  (k_cb)
  );

  // State, instruction and retire-counter registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_FETCH;
      ir_q    <= 32'd0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and IR load; an instruction retires whenever the PC moves.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = (PS != PS_HOLD) ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
    case (state_q)
      ST_FETCH: begin
        ir_d    = inst;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (cls)
          CL_ADD, CL_SUB, CL_AND, CL_ORR, CL_ADDI, CL_SUBI,
          CL_STUR, CL_B: state_d = ST_FETCH;
          CL_LDUR:       state_d = ST_MEM;
          CL_CBZ:        state_d = ST_BRCH;
          default:       state_d = ST_HALT;
        endcase
      end
      ST_MEM:  state_d = ST_FETCH;
      ST_BRCH: state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // Moore output decode; every pin idles at 0 unless the state drives it.
  always_comb begin
    SA = 5'd0; SB = 5'd0; DA = 5'd0; WR = 1'b0; FS = 5'd0; C0 = 1'b0;
    K = 64'd0; M = 1'b0; EN_ALU = 1'b0; EN_ADDR_ALU = 1'b0; EN_B = 1'b0;
    EN_PC = 1'b0; EN_ADDR_PC = 1'b0; PC_SEL = 1'b0; PS = PS_HOLD;
    RCS = 1'b0; RWE = 1'b0; ROE = 1'b0; SFL = 1'b0; halted = 1'b0;
    case (state_q)
      ST_EXEC: begin
        case (cls)
          CL_ADD, CL_SUB, CL_AND, CL_ORR, CL_ADDI, CL_SUBI: begin
            SA = rn; SB = rm; DA = rd;
            EN_ALU = 1'b1; WR = 1'b1; SFL = 1'b1; PS = PS_INC;
            if (cls == CL_ADDI || cls == CL_SUBI) begin
              K = k_alu; M = 1'b1;
            end else begin
              K = 64'd0; M = 1'b0;
            end
            case (cls)
              CL_SUB, CL_SUBI: begin FS = FS_SUB; C0 = 1'b1; end
              CL_AND:          FS = FS_AND;
              CL_ORR:          FS = FS_ORR;
              default:         FS = FS_ADD;
            endcase
          end
          CL_LDUR, CL_STUR: begin
            SA = rn; K = k_dt; M = 1'b1; FS = FS_ADD;
            EN_ADDR_ALU = 1'b1; RCS = 1'b1;
            if (cls == CL_STUR) begin
              SB = rd; EN_B = 1'b1; RWE = 1'b1; PS = PS_INC;
            end else begin
              ROE = 1'b1;
            end
          end
          CL_B: begin
            K = k_br; PC_SEL = 1'b1; PS = PS_OFS;
          end
          CL_CBZ: begin
            SB = rd; FS = FS_PASSB; SFL = 1'b1;
          end
          default: PS = PS_HOLD;
        endcase
      end
      ST_MEM: begin
        SA = rn; K = k_dt; M = 1'b1; FS = FS_ADD; EN_ADDR_ALU = 1'b1;
        RCS = 1'b1; ROE = 1'b1; DA = rd; WR = 1'b1; PS = PS_INC;
      end
      ST_BRCH: begin
        if (PRESTAT[0]) begin
          K = k_cb; PC_SEL = 1'b1; PS = PS_OFS;
        end else begin
          PS = PS_INC;
        end
      end
      ST_HALT: halted = 1'b1;
      default: halted = 1'b0;
    endcase
  end

endmodule

// File: doc/legv8_control_unit.md
Name: legv8_control_unit

Overview:
- Multi-cycle control FSM that consumes the 32-bit instruction word from program ROM.
- Drives every control input of the LEGv8 datapath: register selects, ALU function, bus enables, PC function, RAM strobes and status-flag capture.
- Sits between ROM output and datapath control pins. Sequences fetch, execute, memory and branch cycles, and keeps a retired-instruction counter.

Parameters:
- CNT_W, 16, width of retired-instruction counter.

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- inst  in  32  instruction word from ROM (valid combinationally for current PC)
- PRESTAT  in  4  registered ALU flags {V,C,N,Z}, Z = bit0
- SA  out  5  A-bus register select
- SB  out  5  B-bus register select
- DA  out  5  destination register select
- WR  out  1  register-file write enable
- FS  out  5  ALU function select
- C0  out  1  ALU carry-in
- K  out  64  constant, sign- or zero-extended immediate
- M  out  1  ALU B-input mux (1 = K)
- EN_ALU, EN_ADDR_ALU, EN_B, EN_PC, EN_ADDR_PC, PC_SEL  out  1 each  datapath bus enables
- PS  out  2  PC function: 00 hold, 01 +4, 10 load, 11 add offset
- RCS, RWE, ROE  out  1 each  RAM chip select, write, read
- SFL  out  1  store ALU flags
- halted  out  1  illegal opcode trap
- instr_count  out  CNT_W  retired instructions, wraps at 2^CNT_W

Behaviour:
- One clock; reset is asynchronous and active-low. RST=0 forces:
  - state FETCH, IR=0, instr_count=0, halted=0;
  - every control output 0, PS=00.
- States: FETCH, EXEC, MEM, BRCH, HALT.
- Outputs are Moore-decoded from state and IR only.
- FETCH: IR<=inst; all outputs 0; next EXEC.
- EXEC, decoded from IR[31:21]:
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000:
    - SA=IR[9:5], SB=IR[20:16], DA=IR[4:0], M=0, EN_ALU=1, WR=1, SFL=1, PS=01
    - next FETCH.
  - ADDI 1001000100x, SUBI 1101000100x:
    - K=zero-extended IR[21:10], M=1, otherwise as R-type
    - next FETCH.
  - LDUR 11111000010:
    - SA=IR[9:5], K=sign-extended IR[20:12], M=1, FS=ADD, EN_ADDR_ALU=1, RCS=1, ROE=1
    - next MEM.
  - STUR 11111000000:
    - address as LDUR, SB=IR[4:0], EN_B=1, RCS=1, RWE=1, PS=01
    - next FETCH.
  - B (IR[31:26]=000101):
    - K=sign-extended IR[25:0], PC_SEL=1, PS=11
    - next FETCH.
  - CBZ (IR[31:24]=10110100):
    - SB=IR[4:0], FS=PASSB, M=0, SFL=1
    - next BRCH.
  - Any other opcode: next HALT; PC not advanced.
- MEM (LDUR only):
  - hold address enables, RCS=1, ROE=1, DA=IR[4:0], WR=1, PS=01
  - next FETCH.
- BRCH:
  - if PRESTAT[0]=1: K=sign-extended IR[23:5], PC_SEL=1, PS=11; else PS=01
  - next FETCH.
- HALT: halted=1, all other outputs 0; exit only by reset.
- instr_count increments on the cycle PS≠00 is driven (exactly once per instruction); wraps to 0.
- Sign extension: replicate the top immediate bit to 64.
- Branch offsets are word offsets; the PC block scales them.
- Bus exclusivity: at most one DBUS driver (EN_ALU, EN_B, EN_PC) and at most one RABUS driver (EN_ADDR_ALU, EN_ADDR_PC) active in any state.
- RWE and ROE are never both 1.
- Reset asserted mid-instruction aborts immediately. No partial write occurs after RST falls, because outputs go to 0 asynchronously.
- Instruction latencies: R/I/STUR/B 2 cycles; LDUR/CBZ 3 cycles.

Decomposition:
- Shared package legv8_ctrl_pkg holds:
  - state enum;
  - opcode constants (OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDI, OP_SUBI, OP_LDUR, OP_STUR, OP_B, OP_CBZ);
  - FS constants: FS_AND=00000, FS_ORR=00100, FS_ADD=01000, FS_SUB=01001 (C0=1), FS_PASSB=11100;
  - PS constants.
- One sub-module: legv8_inst_decode. Purely combinational; maps IR to an opcode class, register fields and extended immediates. The FSM uses it.

Test Plan:
- RST low mid-LDUR MEM cycle -> WR, RCS, ROE drop to 0 the same instant; after release the state is FETCH and instr_count=0.
- inst=ADD X3,X1,X2 (0x8B020023) -> EXEC cycle: SA=1, SB=2, DA=3, FS=01000, WR=1, EN_ALU=1, PS=01; instr_count=1.
- inst=ADDI X5,X5,#4 (0x910010A5) then LDUR X6,[X5,#8] -> ADDI: K=4, M=1. LDUR: K=8, EN_ADDR_ALU=1, ROE=1 for 2 cycles; WR=1 with DA=6 only in MEM.
- CBZ X7,#-2 with PRESTAT=0001 in BRCH -> PS=11, K=0xFFFF_FFFF_FFFF_FFFE. With PRESTAT=0000 -> PS=01.
- Illegal inst 0x00000000 -> HALT, halted=1, PS=00 and all enables 0 held for 10+ cycles; only RST clears it.
- 65536 ADD instructions -> instr_count wraps to 0; DBUS and RABUS driver-exclusivity assertions hold every cycle.
